// File: rtl/log_level_meter.sv
// Peak-hold level meter for log2 codes: instant attack, sample-counted hold, linear log release.
// Optional sticky clip flag enabled by defining LOG_METER_CLIP_EN.
module log_level_meter #(
  parameter int unsigned HOLD_SAMPLES = 1024,
  parameter int unsigned DECAY_DIV    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_log,
  input  logic       clip_clr,
  output logic [7:0] peak_out,
  output logic       peak_valid,
  output logic [1:0] state_out,
  output logic       clip
);

  localparam int unsigned HW = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;
  localparam int unsigned DW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_SAMPLES - 1);
  localparam logic [DW-1:0] DECAY_LAST = DW'(DECAY_DIV - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StHold  = 2'b01,
    StDecay = 2'b10
  } state_e;

  state_e        state;
  logic [HW-1:0] hold_cnt;
  logic [DW-1:0] decay_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      peak_out   <= 8'h00;
      peak_valid <= 1'b0;
      hold_cnt   <= '0;
      decay_cnt  <= '0;
    end else begin
      peak_valid <= in_valid;
      if (in_valid) begin
        // Capture wins in every state; equal codes restart the hold.
        if (in_log >= peak_out) begin
          peak_out  <= in_log;
          hold_cnt  <= '0;
          decay_cnt <= '0;
          state     <= StHold;
        end else begin
          case (state)
            StHold: begin
              if (hold_cnt == HOLD_LAST) begin
                state     <= StDecay;
                hold_cnt  <= '0;
                decay_cnt <= '0;
              end else begin
                hold_cnt <= hold_cnt + HW'(1);
              end
            end
            StDecay: begin
              if (decay_cnt == DECAY_LAST) begin
                decay_cnt <= '0;
                if (peak_out <= 8'd1) begin
                  peak_out <= 8'h00;
                  state    <= StIdle;
                end else begin
                  peak_out <= peak_out - 8'd1;
                end
              end else begin
                decay_cnt <= decay_cnt + DW'(1);
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign state_out = state;

`ifdef LOG_METER_CLIP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clip <= 1'b0;
    end else if (in_valid && (in_log == 8'hFF)) begin
      clip <= 1'b1;
    end else if (clip_clr) begin
      clip <= 1'b0;
    end
  end
`else
  logic unused_clip_clr;
  assign unused_clip_clr = clip_clr;
  assign clip = 1'b0;
`endif

endmodule

// File: tb/tb_log_level_meter.sv
// Directed bench for log_level_meter with HOLD_SAMPLES=4, DECAY_DIV=2.
module tb_log_level_meter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_log = 8'h00;
  logic       clip_clr = 1'b0;
  logic [7:0] peak_out;
  logic       peak_valid;
  logic [1:0] state_out;
  logic       clip;

  int vectors = 0;
  int errors  = 0;

  localparam logic [1:0] IDLE = 2'b00, HOLD = 2'b01, DECAY = 2'b10;

  log_level_meter #(
    .HOLD_SAMPLES(4),
    .DECAY_DIV   (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_log    (in_log),
    .clip_clr  (clip_clr),
    .peak_out  (peak_out),
    .peak_valid(peak_valid),
    .state_out (state_out),
    .clip      (clip)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are checked at the same point.
  task automatic send(input logic [7:0] v, input logic clr);
    in_valid = 1'b1;
    in_log   = v;
    clip_clr = clr;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clip_clr = 1'b0;
  endtask

  task automatic idle(input logic clr);
    clip_clr = clr;
    @(posedge clk);
    #1;
    clip_clr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [7:0] seq_in   [11] = '{8'h30, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                                8'h00, 8'h00, 8'h00, 8'h2E, 8'h00};
  logic [7:0] seq_peak [11] = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30,
                                8'h2F, 8'h2F, 8'h2E, 8'h2E, 8'h2E};
  logic [1:0] seq_st   [11] = '{HOLD, HOLD, HOLD, HOLD, DECAY, DECAY,
                                DECAY, DECAY, DECAY, HOLD, HOLD};

  task automatic run_seq(input int max_gap);
    int gap;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      send(seq_in[i], 1'b0);
      check($sformatf("seq_peak[%0d] gap%0d", i, max_gap), 32'(peak_out), 32'(seq_peak[i]));
      check($sformatf("seq_state[%0d] gap%0d", i, max_gap), 32'(state_out), 32'(seq_st[i]));
      gap = (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap));
      repeat (gap) idle(1'b0);
    end
  endtask

  initial begin
    #2;
    check("reset_peak", 32'(peak_out), 32'h00);
    check("reset_state", 32'(state_out), 32'(IDLE));
    check("reset_valid", 32'(peak_valid), 32'h0);
    check("reset_clip", 32'(clip), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Attack and hold
    send(8'h50, 1'b0);
    check("attack_peak", 32'(peak_out), 32'h50);
    check("attack_state", 32'(state_out), 32'(HOLD));
    check("attack_valid", 32'(peak_valid), 32'h1);
    idle(1'b0);
    check("valid_drops", 32'(peak_valid), 32'h0);
    check("idle_keeps_peak", 32'(peak_out), 32'h50);
    for (int i = 0; i < 3; i++) begin
      send(8'h10, 1'b0);
      check($sformatf("hold_peak[%0d]", i), 32'(peak_out), 32'h50);
      check($sformatf("hold_state[%0d]", i), 32'(state_out), 32'(HOLD));
      check($sformatf("hold_valid[%0d]", i), 32'(peak_valid), 32'h1);
    end

    // Equal recapture restarts hold, then release
    send(8'h50, 1'b0);
    for (int i = 0; i < 3; i++) begin
      send(8'h00, 1'b0);
      check($sformatf("rel_hold[%0d]", i), 32'(state_out), 32'(HOLD));
    end
    send(8'h00, 1'b0);
    check("rel_decay_state", 32'(state_out), 32'(DECAY));
    check("rel_decay_peak", 32'(peak_out), 32'h50);
    send(8'h00, 1'b0);
    check("rel_d1_peak", 32'(peak_out), 32'h50);
    send(8'h00, 1'b0);
    check("rel_4f", 32'(peak_out), 32'h4F);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    check("rel_4e", 32'(peak_out), 32'h4E);

    // Recapture during decay
    send(8'h4E, 1'b0);
    check("recap_state", 32'(state_out), 32'(HOLD));
    check("recap_peak", 32'(peak_out), 32'h4E);
    for (int i = 0; i < 3; i++) send(8'h00, 1'b0);
    check("recap_hold_restart", 32'(state_out), 32'(HOLD));
    send(8'h60, 1'b0);
    check("recap_60", 32'(peak_out), 32'h60);

    // Full decay to idle: 4 + 2*0x60 = 196 samples
    for (int i = 0; i < 195; i++) send(8'h00, 1'b0);
    check("decay_last_peak", 32'(peak_out), 32'h01);
    check("decay_last_state", 32'(state_out), 32'(DECAY));
    send(8'h00, 1'b0);
    check("decay_out_peak", 32'(peak_out), 32'h00);
    check("decay_out_state", 32'(state_out), 32'(IDLE));
    send(8'h00, 1'b0);
    check("zero_capture_state", 32'(state_out), 32'(HOLD));
    check("zero_capture_peak", 32'(peak_out), 32'h00);

    // Back-to-back versus gapped samples
    run_seq(0);
    run_seq(5);

    // Async reset mid-decay
    do_reset();
    send(8'h50, 1'b0);
    for (int i = 0; i < 5; i++) send(8'h00, 1'b0);
    check("pre_rst_state", 32'(state_out), 32'(DECAY));
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_peak", 32'(peak_out), 32'h00);
    check("async_rst_state", 32'(state_out), 32'(IDLE));
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1'b0);
    check("post_rst_peak", 32'(peak_out), 32'h00);
    check("post_rst_state", 32'(state_out), 32'(IDLE));

    // Clip flag
`ifdef LOG_METER_CLIP_EN
    send(8'hFF, 1'b0);
    check("clip_set", 32'(clip), 32'h1);
    send(8'hFF, 1'b1);
    check("clip_set_wins", 32'(clip), 32'h1);
    idle(1'b1);
    check("clip_cleared", 32'(clip), 32'h0);
`else
    send(8'hFF, 1'b0);
    check("clip_tied_low", 32'(clip), 32'h0);
    send(8'hFF, 1'b1);
    check("clip_tied_low_clr", 32'(clip), 32'h0);
`endif
    check("ff_peak", 32'(peak_out), 32'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
